// File: rtl/count_check_pkg.sv
// ============================================================================
// count_check_pkg : state encoding and saturating increment for count_checker
// Revision 1.0
// ============================================================================
`default_nettype none

package count_check_pkg;

  typedef enum logic [0:0] {
    SYNC  = 1'b0,
    TRACK = 1'b1
  } state_e;

  // Increment val, holding at 2^width-1 instead of rolling over (width <= 64).
  function automatic logic [63:0] sat_inc(input logic [63:0] val, input int unsigned width);
    logic [63:0] top;
    top = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (val >= top) ? top : (val + 64'd1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/count_check_event_slot.sv
// ============================================================================
// count_check_event_slot : one-entry valid/ready mismatch holder, sticky loss
// Revision 1.0
// ============================================================================
`default_nettype none

module count_check_event_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_i,
  input  logic [WIDTH-1:0] expected_i,
  input  logic [WIDTH-1:0] actual_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] expected_o,
  output logic [WIDTH-1:0] actual_o,
  output logic             lost_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [WIDTH-1:0] actual_q, actual_d;
  logic             lost_q, lost_d;
  logic             accept;

  assign accept = valid_q & ready_i;

  always_comb begin
    valid_d    = valid_q;
    expected_d = expected_q;
    actual_d   = actual_q;
    lost_d     = lost_q;
    if (clear) begin
      valid_d    = 1'b0;
      expected_d = '0;
      actual_d   = '0;
      lost_d     = 1'b0;
    end else if (load_i) begin
      // An accept on this edge frees the slot for the incoming pair.
      if (!valid_q || accept) begin
        valid_d    = 1'b1;
        expected_d = expected_i;
        actual_d   = actual_i;
      end else begin
        lost_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= 1'b0;
      expected_q <= '0;
      actual_q   <= '0;
      lost_q     <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      expected_q <= expected_d;
      actual_q   <= actual_d;
      lost_q     <= lost_d;
    end
  end

  assign valid_o    = valid_q;
  assign expected_o = expected_q;
  assign actual_o   = actual_q;
  assign lost_o     = lost_q;

endmodule

`default_nettype wire

// File: rtl/count_checker.sv
// ============================================================================
// count_checker : checks a free-running counter steps by +1 mod 2^WIDTH
// Revision 1.0
// ============================================================================
`default_nettype none

module count_checker
  import count_check_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic [WIDTH-1:0] in,
  output logic             locked,
  output logic [CNT_W-1:0] wrap_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_valid,
  input  logic             err_ready,
  output logic [WIDTH-1:0] err_expected,
  output logic [WIDTH-1:0] err_actual,
  output logic             err_lost
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] wrap_q, wrap_d;
  logic [CNT_W-1:0] errc_q, errc_d;

  logic [WIDTH-1:0] expected;
  logic             mismatch;
  logic             wrap;

  assign expected = prev_q + WIDTH'(1);
  assign mismatch = (state_q == TRACK) && (in != expected);
  assign wrap     = (state_q == TRACK) && (in == expected) && (prev_q == {WIDTH{1'b1}});

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    wrap_d  = wrap_q;
    errc_d  = errc_q;
    if (clear) begin
      state_d = SYNC;
      prev_d  = '0;
      wrap_d  = '0;
      errc_d  = '0;
    end else begin
      // Always follow the actual value so one glitch yields one error.
      prev_d = in;
      case (state_q)
        SYNC: begin
          state_d = TRACK;
        end
        TRACK: begin
          if (wrap) begin
            wrap_d = CNT_W'(sat_inc(64'(wrap_q), CNT_W));
          end
          if (mismatch) begin
            errc_d = CNT_W'(sat_inc(64'(errc_q), CNT_W));
          end
        end
        default: begin
          state_d = SYNC;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SYNC;
      prev_q  <= '0;
      wrap_q  <= '0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      wrap_q  <= wrap_d;
      errc_q  <= errc_d;
    end
  end

  count_check_event_slot #(
    .WIDTH (WIDTH)
  ) u_slot (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .load_i     (mismatch),
    .expected_i (expected),
    .actual_i   (in),
    .ready_i    (err_ready),
    .valid_o    (err_valid),
    .expected_o (err_expected),
    .actual_o   (err_actual),
    .lost_o     (err_lost)
  );

  assign locked     = (state_q == TRACK);
  assign wrap_count = wrap_q;
  assign err_count  = errc_q;

endmodule

`default_nettype wire

// File: tb/tb_count_checker.sv
// ============================================================================
// tb_count_checker : directed bench for an 8-bit and a 3-bit count_checker
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_count_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;
  logic [7:0] in8 = '0;
  logic [2:0] in3 = '0;

  logic        l8, v8, lo8;
  logic [15:0] wc8, ec8;
  logic [7:0]  ex8, ac8;
  logic        l3, v3, lo3;
  logic [2:0]  wc3, ec3;
  logic [2:0]  ex3, ac3;

  int checks   = 0;
  int failures = 0;
  int k3       = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  count_checker #(.WIDTH(8), .CNT_W(16)) dut8 (
    .clk(clk), .reset(rst), .clear(clr), .in(in8), .locked(l8),
    .wrap_count(wc8), .err_count(ec8), .err_valid(v8), .err_ready(rdy),
    .err_expected(ex8), .err_actual(ac8), .err_lost(lo8)
  );

  count_checker #(.WIDTH(3), .CNT_W(3)) dut3 (
    .clk(clk), .reset(rst), .clear(clr), .in(in3), .locked(l3),
    .wrap_count(wc3), .err_count(ec3), .err_valid(v3), .err_ready(rdy),
    .err_expected(ex3), .err_actual(ac3), .err_lost(lo3)
  );

  // Behavioural model: what an ideal checker has observed so far.
  typedef struct {
    bit          locked;
    int unsigned prev;
    int unsigned wrapc;
    int unsigned errc;
    bit          ev;
    int unsigned ev_exp;
    int unsigned ev_act;
    bit          lost;
  } m_t;

  function automatic m_t mzero();
    m_t z;
    z.locked = 0; z.prev = 0; z.wrapc = 0; z.errc = 0;
    z.ev = 0; z.ev_exp = 0; z.ev_act = 0; z.lost = 0;
    return z;
  endfunction

  function automatic m_t mstep(m_t m, int unsigned w, int unsigned cw,
                               int unsigned x, bit c, bit r);
    int unsigned mask, cmax, nxt;
    bit          take;
    mask = (1 << w) - 1;
    cmax = (1 << cw) - 1;
    if (c) return mzero();
    if (!m.locked) begin
      m.locked = 1;
      m.prev   = x;
      return m;
    end
    nxt  = (m.prev + 1) & mask;
    take = m.ev && r;
    if (x == nxt) begin
      if (m.prev == mask && m.wrapc < cmax) m.wrapc++;
      if (take) m.ev = 0;
    end else begin
      if (m.errc < cmax) m.errc++;
      if (!m.ev || take) begin
        m.ev = 1; m.ev_exp = nxt; m.ev_act = x;
      end else begin
        m.lost = 1;
      end
    end
    m.prev = x;
    return m;
  endfunction

  m_t m8, m3;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m8 <= mzero();
      m3 <= mzero();
    end else begin
      m8 <= mstep(m8, 8, 16, 32'(in8), clr, rdy);
      m3 <= mstep(m3, 3, 3, 32'(in3), clr, rdy);
    end
  end

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      cmp("locked8",   32'(l8),  32'(m8.locked));
      cmp("wrap8",     32'(wc8), m8.wrapc);
      cmp("errc8",     32'(ec8), m8.errc);
      cmp("valid8",    32'(v8),  32'(m8.ev));
      cmp("expected8", 32'(ex8), m8.ev_exp);
      cmp("actual8",   32'(ac8), m8.ev_act);
      cmp("lost8",     32'(lo8), 32'(m8.lost));
      cmp("locked3",   32'(l3),  32'(m3.locked));
      cmp("wrap3",     32'(wc3), m3.wrapc);
      cmp("errc3",     32'(ec3), m3.errc);
      cmp("valid3",    32'(v3),  32'(m3.ev));
      cmp("expected3", 32'(ex3), m3.ev_exp);
      cmp("actual3",   32'(ac3), m3.ev_act);
      cmp("lost3",     32'(lo3), 32'(m3.lost));
    end
  end

  task automatic step(input logic [7:0] a, input logic [2:0] b);
    in8 = a;
    in3 = b;
    @(posedge clk);
    #2;
  endtask

  task automatic step8(input logic [7:0] a);
    step(a, 3'(k3));
    k3++;
  endtask

  task automatic all_zero8(input string nm);
    cmp({nm, "_locked"}, 32'(l8),  0);
    cmp({nm, "_wrap"},   32'(wc8), 0);
    cmp({nm, "_errc"},   32'(ec8), 0);
    cmp({nm, "_valid"},  32'(v8),  0);
    cmp({nm, "_exp"},    32'(ex8), 0);
    cmp({nm, "_act"},    32'(ac8), 0);
    cmp({nm, "_lost"},   32'(lo8), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 cmp_en = 1'b1;
    @(posedge clk); #2;
    all_zero8("reset");
    rst = 1'b0;

    // Clean count on both checkers, err_ready held high.
    rdy = 1'b1;
    for (int i = 0; i <= 600; i++) begin
      step(8'(i % 256), 3'(i % 8));
      if (i == 1) cmp("lock_at_1", 32'(l8), 1);
      if (i == 40) cmp("narrow_wrap40", 32'(wc3), 5);
    end
    cmp("clean_wrap8", 32'(wc8), 2);
    cmp("clean_err8",  32'(ec8), 0);
    cmp("narrow_wrap_sat", 32'(wc3), 7);

    // Single mismatch with resync.
    rdy = 1'b0;
    clr = 1'b1; step8(0); clr = 1'b0;
    step8(5); step8(6); step8(9);
    cmp("single_valid", 32'(v8),  1);
    cmp("single_exp",   32'(ex8), 7);
    cmp("single_act",   32'(ac8), 9);
    cmp("single_errc",  32'(ec8), 1);
    step8(10);
    cmp("resync_errc",  32'(ec8), 1);

    // Backpressure loss.
    clr = 1'b1; step8(0); clr = 1'b0;
    step8(1); step8(2); step8(7); step8(8); step8(3);
    cmp("bp_exp",  32'(ex8), 3);
    cmp("bp_act",  32'(ac8), 7);
    cmp("bp_errc", 32'(ec8), 2);
    cmp("bp_lost", 32'(lo8), 1);
    rdy = 1'b1; step8(4); rdy = 1'b0;
    cmp("bp_drain_valid", 32'(v8),  0);
    cmp("bp_lost_sticky", 32'(lo8), 1);
    step8(5);
    clr = 1'b1; step8(0); clr = 1'b0;
    cmp("clear_lost", 32'(lo8), 0);

    // Simultaneous accept and new mismatch.
    step8(1); step8(2); step8(7); step8(8);
    rdy = 1'b1; step8(4);
    cmp("simul_valid", 32'(v8),  1);
    cmp("simul_exp",   32'(ex8), 9);
    cmp("simul_act",   32'(ac8), 4);
    cmp("simul_lost",  32'(lo8), 0);

    // Sustained one error per cycle; narrow 7->1 and error saturation.
    step(8'd100, 3'd6); step(8'd110, 3'd7); step(8'd120, 3'd1);
    cmp("narrow_exp", 32'(ex3), 0);
    cmp("narrow_act", 32'(ac3), 1);
    for (int j = 3; j < 13; j++) step(8'(100 + 10 * j), 3'((1 + 2 * (j - 2)) % 8));
    cmp("tput_errc",  32'(ec8), 15);
    cmp("tput_lost",  32'(lo8), 0);
    cmp("tput_exp",   32'(ex8), 211);
    cmp("tput_act",   32'(ac8), 220);
    cmp("narrow_err_sat", 32'(ec3), 7);

    // Reset pulse mid-cycle while an event is pending.
    rdy = 1'b0;
    step8(0);
    cmp("pend_valid", 32'(v8), 1);
    rst = 1'b1;
    #1 all_zero8("midreset");
    #1 rst = 1'b0;
    step8(37);
    cmp("relock", 32'(l8), 1);
    step8(38);
    cmp("relock_errc",  32'(ec8), 0);
    cmp("relock_valid", 32'(v8),  0);
    step8(39);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
